// File: rtl/axi4_s_rd_responder_pkg.sv
// axi4_s_rd_pkg: shared definitions for the AXI4-Lite read responder.
//   RESP_* : AXI read response codes written into the R FIFO.
//   rd_state_e : responder FSM states.
//   word_shift() : right-shift that turns a byte offset into a local word
//                  index for a given data width.
package axi4_s_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH
  } rd_state_e;

  // 32-bit data gives 2, 64-bit data gives 3.
  function automatic int unsigned word_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_s_rd_responder_if.sv
// axi4_s_rd_responder_if: bundles the three queue/bus sides of the responder.
//   AR FIFO read side : ar_rd_empty, araddr (first-word fall-through), ar_rd_en
//   R FIFO write side : r_wr_full, r_wr_en, rdata, rresp
//   local read port   : mem_rd_req, mem_rd_addr, mem_rd_ack, mem_rd_data, mem_rd_err
// Modport slave is the responder's view; modport master is the environment
// (FIFOs plus local memory) seen from the other side.
interface axi4_s_rd_responder_if #(
  parameter int A  = 32,
  parameter int D  = 32,
  parameter int MA = 10
);

  logic          ar_rd_empty;
  logic [A-1:0]  araddr;
  logic          ar_rd_en;

  logic          r_wr_full;
  logic          r_wr_en;
  logic [D-1:0]  rdata;
  logic [1:0]    rresp;

  logic          mem_rd_req;
  logic [MA-1:0] mem_rd_addr;
  logic          mem_rd_ack;
  logic [D-1:0]  mem_rd_data;
  logic          mem_rd_err;

  modport slave (
    input  ar_rd_empty, araddr,
    output ar_rd_en,
    input  r_wr_full,
    output r_wr_en, rdata, rresp,
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_ack, mem_rd_data, mem_rd_err
  );

  modport master (
    output ar_rd_empty, araddr,
    input  ar_rd_en,
    output r_wr_full,
    input  r_wr_en, rdata, rresp,
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_ack, mem_rd_data, mem_rd_err
  );

endinterface

// File: rtl/axi4_s_rd_responder_timeout_cnt.sv
// axi4_rd_timeout_cnt: watchdog for an outstanding local read request.
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : high while the responder is waiting in REQ
//   ack        : local read acknowledge
//   expired    : high in the REQ cycle where the wait has reached
//                TIMEOUT_CYCLES-1 without an ack; an ack in that cycle wins
module axi4_rd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  // Held at zero outside REQ, so every REQ entry starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (active && !ack) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign expired = active && !ack && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi4_s_rd_responder.sv
// axi4_s_rd_responder: pops AXI4-Lite read addresses from the AR FIFO,
// decodes them against [BASE_ADDR, BASE_ADDR+SPAN), reads the local bus
// with a level req/ack handshake, and pushes data plus response into the
// R FIFO. One transaction in flight; responses stay in AR order.
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus (slave)   : AR FIFO read side, R FIFO write side, local read port
// Optional macro AXI4_S_RD_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on the
// local request that aborts with SLVERR; without it REQ waits indefinitely.
module axi4_s_rd_responder
  import axi4_s_rd_pkg::*;
#(
  parameter int           A              = 32,
  parameter int           D              = 32,
  parameter logic [A-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [A-1:0] SPAN           = 32'h0000_1000,
  parameter int           MA             = 10,
  parameter int           TIMEOUT_CYCLES = 256
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi4_s_rd_responder_if.slave   bus
);

  localparam int unsigned WORD_SHIFT = word_shift(D);

  // Reject configurations that cannot work instead of building them.
  if (!(D == 32 || D == 64)) begin : g_bad_width
    $error("axi4_s_rd_responder: D must be 32 or 64");
  end
  if (((64'd1 << MA) * 64'(D / 8)) < 64'(SPAN)) begin : g_bad_ma
    $error("axi4_s_rd_responder: MA too small to cover SPAN");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_s_rd_responder: TIMEOUT_CYCLES must be at least 1");
  end

  rd_state_e     state, state_next;
  logic [D-1:0]  rdata_q;
  logic [1:0]    rresp_q;
  logic [MA-1:0] addr_q;

  // One extra bit so BASE_ADDR+SPAN reaching 2**A does not wrap to zero.
  logic [A:0]    addr_ext, win_lo, win_hi;
  logic          hit;
  logic [A-1:0]  offset;
  logic [MA-1:0] word_addr;
  logic          timeout_hit;

  assign addr_ext  = {1'b0, bus.araddr};
  assign win_lo    = {1'b0, BASE_ADDR};
  assign win_hi    = win_lo + {1'b0, SPAN};
  assign hit       = (addr_ext >= win_lo) && (addr_ext < win_hi);
  assign offset    = bus.araddr - BASE_ADDR;
  assign word_addr = MA'(offset >> WORD_SHIFT);

`ifdef AXI4_S_RD_TIMEOUT_EN
  axi4_rd_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (aclk),
    .rst_n   (aresetn),
    .active  (state == REQ),
    .ack     (bus.mem_rd_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; an asynchronous reset drops any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the three strobes. Pop and push are combinational so a
  // miss completes in two cycles and a zero-wait hit in three.
  always_comb begin
    state_next     = state;
    bus.ar_rd_en   = 1'b0;
    bus.r_wr_en    = 1'b0;
    bus.mem_rd_req = 1'b0;
    case (state)
      IDLE: begin
        bus.ar_rd_en = ~bus.ar_rd_empty;
        if (!bus.ar_rd_empty) begin
          state_next = hit ? REQ : PUSH;
        end
      end
      REQ: begin
        bus.mem_rd_req = 1'b1;
        if (bus.mem_rd_ack || timeout_hit) begin
          state_next = PUSH;
        end
      end
      PUSH: begin
        bus.r_wr_en = ~bus.r_wr_full;
        if (!bus.r_wr_full) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response and local address registers. They only load on a pop or on
  // leaving REQ, so they hold steady through REQ waits and PUSH stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.ar_rd_empty) begin
            if (hit) begin
              addr_q <= word_addr;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_DECERR;
            end
          end
        end
        REQ: begin
          if (bus.mem_rd_ack) begin
            rdata_q <= bus.mem_rd_data;
            rresp_q <= bus.mem_rd_err ? RESP_SLVERR : RESP_OKAY;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rresp       = rresp_q;
  assign bus.mem_rd_addr = addr_q;

endmodule

// File: doc/axi4_s_rd_responder.md
Name: axi4_s_rd_responder

Overview:
- Sits directly downstream of the AXI4-Lite slave read-channel FIFOs. Pops read addresses from the AR FIFO and performs a read on a simple local memory/register bus.
- Pushes the resulting data and response into the R FIFO.
- Bridges queued AXI4-Lite reads to a req/ack local read port with variable latency and address-range decode.

Parameters:
- A, 32, AXI address width.
- D, 32, data width: 32 or 64.
- BASE_ADDR, 32'h0000_0000, first byte address claimed by this slave.
- SPAN, 32'h0000_1000, size in bytes of the claimed window; power of two.
- MA, 10, local word-address width; must satisfy 2**MA * (D/8) >= SPAN.
- TIMEOUT_CYCLES, 256, cycles without ack before abort; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- ar_rd_empty  in  1  AR FIFO empty.
- araddr  in  A  AR FIFO head entry; first-word fall-through, valid while ar_rd_empty=0.
- ar_rd_en  out  1  AR FIFO pop.
- r_wr_full  in  1  R FIFO full.
- r_wr_en  out  1  R FIFO push.
- rdata  out  D  R FIFO write data.
- rresp  out  2  R FIFO write response.
- mem_rd_req  out  1  local read request; level, held until ack.
- mem_rd_addr  out  MA  local word address.
- mem_rd_ack  in  1  local read done; mem_rd_data and mem_rd_err are valid this cycle.
- mem_rd_data  in  D  local read data.
- mem_rd_err  in  1  local read error.

Behaviour:
- Clock and reset: one clock, aclk. aresetn is asynchronous, active low.
- Reset values:
  - State = IDLE.
  - ar_rd_en, r_wr_en and mem_rd_req = 0.
  - rdata = 0, rresp = 2'b00, mem_rd_addr = 0.
- Reset mid-transaction aborts it with no R push. An outstanding local request is dropped and the local slave must tolerate that.
- FSM states: IDLE, REQ, PUSH.
- IDLE:
  - ar_rd_en = ~ar_rd_empty, combinational.
  - On a pop edge, decode araddr.
  - Hit: BASE_ADDR <= araddr < BASE_ADDR+SPAN.
    - Register mem_rd_addr = (araddr-BASE_ADDR) >> log2(D/8), truncated to MA bits.
    - Low address bits are ignored; no unaligned error.
    - Go to REQ.
  - Miss: rdata = 0, rresp = DECERR 2'b11, go to PUSH. No local access.
- REQ:
  - mem_rd_req = 1; mem_rd_addr is held stable.
  - On mem_rd_ack: capture rdata = mem_rd_data; rresp = mem_rd_err ? SLVERR 2'b10 : OKAY 2'b00; deassert mem_rd_req on the next edge; go to PUSH.
  - Ack may arrive in the first REQ cycle.
  - mem_rd_ack outside REQ is ignored.
- PUSH:
  - r_wr_en = ~r_wr_full, combinational.
  - When pushed, go to IDLE.
  - While the R FIFO is full, stall in PUSH with rdata/rresp held. No further AR pops occur.
- Ordering and throughput:
  - Exactly one transaction in flight; responses are strictly in AR order.
  - Minimum 3 cycles per hit read (pop, REQ with immediate ack, push); 2 per miss.
- Latency: AR head available to R push is 3 cycles for a hit with zero-wait ack.
- Boundary cases:
  - AR FIFO empty in IDLE: no pop, outputs idle.
  - araddr exactly BASE_ADDR+SPAN-1 byte: hit.
  - araddr exactly BASE_ADDR+SPAN: miss.
  - Range compare uses A+1-bit arithmetic, so there is no wrap when BASE_ADDR+SPAN = 2**A.
  - R FIFO full on PUSH entry: hold indefinitely.

Optional Feature:
- Macro AXI4_S_RD_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: drop mem_rd_req, rdata = 0, rresp = SLVERR 2'b10, go to PUSH.
  - An ack arriving in that same cycle wins over the timeout.
  - A late ack after abort is ignored.
- Undefined: no counter; REQ waits for ack forever.

Decomposition:
- Package axi4_s_rd_pkg:
  - Response constants RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11.
  - FSM state enum.
  - Function for the byte-to-word shift, log2(D/8).
- One natural sub-module: axi4_rd_timeout_cnt. It holds the counter and expiry flag, is parameterised by TIMEOUT_CYCLES, and is instantiated only under AXI4_S_RD_TIMEOUT_EN.

Test Plan:
- Hit read with 0-wait ack:
  - Stimulus: araddr=32'h0000_0010, D=32, mem_rd_data=32'hCAFE_F00D at ack in the first REQ cycle.
  - Response: mem_rd_addr=4; one push with rdata=32'hCAFE_F00D, rresp=00; 3 cycles from pop to push.
- Miss:
  - Stimulus: araddr=32'h0000_1000.
  - Response: no mem_rd_req; push with rdata=0, rresp=11.
  - Boundary: araddr=32'h0000_0FFC is a hit with mem_rd_addr=1023.
- Local error plus backpressure:
  - Stimulus: mem_rd_err=1 on ack; r_wr_full=1 for 10 cycles.
  - Response: rresp=10 held stable; ar_rd_en stays 0 throughout; push occurs the cycle full drops.
- Ordering:
  - Stimulus: 4 back-to-back ARs (0x0, 0x4, 0x2000, 0x8) with ack delays 5, 0, -, 2.
  - Response: R pushes in order with resp 00, 00, 11, 00 and matching data.
- Reset mid-REQ:
  - Stimulus: aresetn low asynchronously 2 cycles into REQ.
  - Response: mem_rd_req falls immediately; no R push; the next AR is processed normally after release.
- Timeout (AXI4_S_RD_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: no ack ever.
  - Response: mem_rd_req high for 8 cycles, then push with rresp=10, rdata=0; a later stray ack is ignored.
